// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - weight/feature buffer and skewing sequencer feeding a DIMxDIM systolic array
//
// Purpose:
//   Buffers one weight matrix B (DIM rows) and one feature matrix A (ROWS rows)
//   written a row at a time. On start it drives the weight-load sequence on
//   sa_load/sa_RD, then streams A onto sa_FDi with lane j delayed by j cycles.
//
// Ports:
//   sa_clk, sa_rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  row write handshake; in_sel 0 = B row, 1 = A row
//   in_row             row data, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   start              job start pulse, honoured only in IDLE with both buffers full
//   busy, done         job in progress / one-cycle completion pulse
//   sa_load, sa_RD     weight-load enable and weight row to the array
//   sa_FDi             skewed feature data to the array
//
// Build option:
//   SF_WEIGHT_REUSE_EN  keep B across jobs; jobs after the first skip LOAD_W.
module systolic_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 2,
    parameter int ROWS       = 2
) (
    input  logic                      sa_clk,
    input  logic                      sa_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sel,
    input  logic [DIM*DATA_WIDTH-1:0] in_row,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      sa_load,
    output logic [DIM*DATA_WIDTH-1:0] sa_RD,
    output logic [DIM*DATA_WIDTH-1:0] sa_FDi
);

    localparam int RW  = DIM * DATA_WIDTH;
    localparam int BCW = $clog2(DIM + 1);
    localparam int ACW = $clog2(ROWS + 1);
    localparam int BIW = $clog2(DIM);
    localparam int AIW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW  = $clog2(ROWS + DIM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_W,
        S_FEED,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BCW-1:0]   b_cnt_q, b_cnt_d;
    logic [ACW-1:0]   a_cnt_q, a_cnt_d;
    logic [RW-1:0]    b_mem_q [DIM];
    logic [RW-1:0]    b_mem_d [DIM];
    logic [RW-1:0]    a_mem_q [ROWS];
    logic [RW-1:0]    a_mem_d [ROWS];
    logic             sa_load_q, sa_load_d;
    logic [RW-1:0]    sa_rd_q, sa_rd_d;
    logic [RW-1:0]    sa_fdi_q, sa_fdi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             b_room;
    logic             start_ok;
    logic             skip_load;
    int               r;

`ifdef SF_WEIGHT_REUSE_EN
    // loaded_q: the array already holds the buffered B; wv_q: B is complete and locked.
    logic             loaded_q, loaded_d;
    logic             wv_q, wv_d;
    assign b_room    = !wv_q && (b_cnt_q < BCW'(DIM));
    assign skip_load = loaded_q;
`else
    assign b_room    = (b_cnt_q < BCW'(DIM));
    assign skip_load = 1'b0;
`endif

    assign in_ready = (state_q == S_IDLE) && (in_sel ? (a_cnt_q < ACW'(ROWS)) : b_room);

    // Counts are sampled before this cycle's write, so a same-cycle final write cannot enable start.
    assign start_ok = start && (state_q == S_IDLE) && (a_cnt_q == ACW'(ROWS)) && (b_cnt_q == BCW'(DIM));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_cnt_d = b_cnt_q;
        a_cnt_d = a_cnt_q;
        b_mem_d = b_mem_q;
        a_mem_d = a_mem_q;
        r       = 0;
`ifdef SF_WEIGHT_REUSE_EN
        loaded_d = loaded_q;
`endif

        if (in_valid && in_ready) begin
            if (in_sel) begin
                a_mem_d[a_cnt_q[AIW-1:0]] = in_row;
                a_cnt_d = a_cnt_q + ACW'(1);
            end else begin
                b_mem_d[b_cnt_q[BIW-1:0]] = in_row;
                b_cnt_d = b_cnt_q + BCW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = skip_load ? S_FEED : S_LOAD_W;
                    cnt_d   = '0;
                end
            end
            S_LOAD_W: begin
                if (int'(cnt_q) == DIM - 1) begin
                    state_d = S_FEED;
                    cnt_d   = '0;
`ifdef SF_WEIGHT_REUSE_EN
                    loaded_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FEED: begin
                if (int'(cnt_q) == ROWS + DIM - 2) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                a_cnt_d = '0;
`ifndef SF_WEIGHT_REUSE_EN
                b_cnt_d = '0;
`endif
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SF_WEIGHT_REUSE_EN
        wv_d = wv_q || (b_cnt_d == BCW'(DIM));
`endif

        // Outputs are registered from the next state so they line up with the state they describe.
        sa_load_d = (state_d == S_LOAD_W);
        busy_d    = (state_d == S_LOAD_W) || (state_d == S_FEED);
        done_d    = (state_d == S_DONE);
        sa_rd_d   = '0;
        sa_fdi_d  = '0;
        if (state_d == S_LOAD_W) begin
            sa_rd_d = b_mem_q[cnt_d[BIW-1:0]];
        end
        if (state_d == S_FEED) begin
            // Lane j runs j cycles behind lane 0: at step t it carries A[t-j][j].
            for (int j = 0; j < DIM; j++) begin
                r = int'(cnt_d) - j;
                if (r >= 0 && r < ROWS) begin
                    sa_fdi_d[j*DATA_WIDTH +: DATA_WIDTH] = a_mem_q[r[AIW-1:0]][j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge sa_clk or negedge sa_rst_n) begin
        if (!sa_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            b_cnt_q   <= '0;
            a_cnt_q   <= '0;
            sa_load_q <= 1'b0;
            sa_rd_q   <= '0;
            sa_fdi_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < DIM; i++) b_mem_q[i] <= '0;
            for (int i = 0; i < ROWS; i++) a_mem_q[i] <= '0;
`ifdef SF_WEIGHT_REUSE_EN
            loaded_q  <= 1'b0;
            wv_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b_cnt_q   <= b_cnt_d;
            a_cnt_q   <= a_cnt_d;
            sa_load_q <= sa_load_d;
            sa_rd_q   <= sa_rd_d;
            sa_fdi_q  <= sa_fdi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            b_mem_q   <= b_mem_d;
            a_mem_q   <= a_mem_d;
`ifdef SF_WEIGHT_REUSE_EN
            loaded_q  <= loaded_d;
            wv_q      <= wv_d;
`endif
        end
    end

    assign sa_load = sa_load_q;
    assign sa_RD   = sa_rd_q;
    assign sa_FDi  = sa_fdi_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder (DIM=2, ROWS=2, DATA_WIDTH=16)
module tb_systolic_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sel = 1'b0;
    logic [31:0] in_row = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        sa_load;
    logic [31:0] sa_RD;
    logic [31:0] sa_FDi;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        d;
        logic        b;
        logic        l;
        logic [31:0] rd;
        logic [31:0] fdi;
    } rec_t;

    rec_t exp_q[$];

    systolic_feeder #(.DATA_WIDTH(16), .DIM(2), .ROWS(2)) dut (
        .sa_clk   (clk),
        .sa_rst_n (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_row   (in_row),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sa_load  (sa_load),
        .sa_RD    (sa_RD),
        .sa_FDi   (sa_FDi)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input int l0, input int l1);
        return {16'(l1), 16'(l0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push(input logic d, input logic b, input logic l, input logic [31:0] rd, input logic [31:0] fdi);
        rec_t e;
        e = '{d: d, b: b, l: l, rd: rd, fdi: fdi};
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle in which the DUT shows job activity is one scoreboard entry.
    always @(negedge clk) begin
        rec_t g;
        rec_t e;
        if (rst_n && (busy || done || sa_load)) begin
            g = '{d: done, b: busy, l: sa_load, rd: sa_RD, fdi: sa_FDi};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got done=%0b busy=%0b load=%0b rd=%h fdi=%h, want no activity",
                         g.d, g.b, g.l, g.rd, g.fdi);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL job_cycle: got done=%0b busy=%0b load=%0b rd=%h fdi=%h, want done=%0b busy=%0b load=%0b rd=%h fdi=%h",
                             g.d, g.b, g.l, g.rd, g.fdi, e.d, e.b, e.l, e.rd, e.fdi);
                end
            end
        end
    end

    task automatic write_row(input logic sel, input int l0, input int l1);
        in_sel   = sel;
        in_row   = pk(l0, l1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_timeout: got no done, want done within 40 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_default();
        write_row(1'b0, 1, 2);
        write_row(1'b0, 3, 4);
        write_row(1'b1, 5, 6);
        write_row(1'b1, 7, 8);
    endtask

    task automatic push_default_job();
        push(0, 1, 1, pk(1, 2), pk(0, 0));
        push(0, 1, 1, pk(3, 4), pk(0, 0));
        push(0, 1, 0, pk(0, 0), pk(5, 0));
        push(0, 1, 0, pk(0, 0), pk(7, 6));
        push(0, 1, 0, pk(0, 0), pk(0, 8));
        push(1, 0, 0, pk(0, 0), pk(0, 0));
    endtask

    initial begin
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_load", 32'(sa_load), 32'd0);
        chk("reset_rd", sa_RD, 32'd0);
        chk("reset_fdi", sa_FDi, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef SF_WEIGHT_REUSE_EN
        load_default();
        push_default_job();
        pulse_start();
        wait_done("reuse_job1");
        chk("reuse_b_locked", 32'(in_ready), 32'd0);
        write_row(1'b1, 9, 10);
        write_row(1'b1, 11, 12);
        push(0, 1, 0, pk(0, 0), pk(9, 0));
        push(0, 1, 0, pk(0, 0), pk(11, 10));
        push(0, 1, 0, pk(0, 0), pk(0, 12));
        push(1, 0, 0, pk(0, 0), pk(0, 0));
        pulse_start();
        wait_done("reuse_job2");
`else
        // Scenario 1 + 3: third B write stalls, A side stays open, stored B unchanged.
        write_row(1'b0, 1, 2);
        write_row(1'b0, 3, 4);
        in_sel   = 1'b0;
        in_row   = pk(99, 98);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("full_b_ready", 32'(in_ready), 32'd0);
        in_sel = 1'b1;
        #1;
        chk("a_side_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        in_sel   = 1'b0;
        @(posedge clk);
        #1;
        write_row(1'b1, 5, 6);
        write_row(1'b1, 7, 8);
        push_default_job();
        pulse_start();
        wait_done("job1");
        chk("c7_in_ready", 32'(in_ready), 32'd1);
        chk("c7_busy", 32'(busy), 32'd0);

        // Scenario 2: start with one A row is ignored.
        write_row(1'b0, 1, 2);
        write_row(1'b0, 3, 4);
        write_row(1'b1, 5, 6);
        pulse_start();
        chk("early_start_busy", 32'(busy), 32'd0);
        chk("early_start_load", 32'(sa_load), 32'd0);
        write_row(1'b1, 7, 8);
        push_default_job();
        pulse_start();
        wait_done("job2");

        // Scenario 5: start alongside the last A write uses pre-write counts.
        write_row(1'b0, 10, 20);
        write_row(1'b0, 30, 40);
        write_row(1'b1, 50, 60);
        in_sel   = 1'b1;
        in_row   = pk(70, 80);
        in_valid = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        start    = 1'b0;
        chk("same_cycle_start_busy", 32'(busy), 32'd0);
        push(0, 1, 1, pk(10, 20), pk(0, 0));
        push(0, 1, 1, pk(30, 40), pk(0, 0));
        push(0, 1, 0, pk(0, 0), pk(50, 0));
        push(0, 1, 0, pk(0, 0), pk(70, 60));
        push(0, 1, 0, pk(0, 0), pk(0, 80));
        push(1, 0, 0, pk(0, 0), pk(0, 0));
        pulse_start();
        wait_done("job3");

        // Scenario 4: reset during FEED t=1.
        load_default();
        push(0, 1, 1, pk(1, 2), pk(0, 0));
        push(0, 1, 1, pk(3, 4), pk(0, 0));
        push(0, 1, 0, pk(0, 0), pk(5, 0));
        push(0, 1, 0, pk(0, 0), pk(7, 6));
        pulse_start();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_load", 32'(sa_load), 32'd0);
        chk("midreset_rd", sa_RD, 32'd0);
        chk("midreset_fdi", sa_FDi, 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        chk("post_reset_start_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("post_reset_start_load", 32'(sa_load), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Upstream stage of systolic_array_2x2 and its larger DIMxDIM variants. It buffers one weight matrix B (DIM rows) and one feature matrix A (ROWS rows) from a row-wide write interface. On start it runs the weight-load sequence on sa_RD/sa_load, then streams A with per-lane diagonal skew onto sa_FDi. This replaces the file-driven stimulus with a synthesizable sequencer.

Parameters:
DATA_WIDTH, 16, width of one matrix element
DIM, 2, array dimension (lanes); range 2..8
ROWS, 2, rows of A per job; range 1..16

Ports:
sa_clk  in  1  clock, rising edge
sa_rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  row write valid
in_ready  out  1  row write ready
in_sel  in  1  0 = row belongs to B, 1 = row belongs to A
in_row  in  DIM*DATA_WIDTH  row data; lane j at bits [j*DATA_WIDTH +: DATA_WIDTH]
start  in  1  job start request (single-cycle pulse)
busy  out  1  job in progress
done  out  1  one-cycle pulse on job completion
sa_load  out  1  weight-load enable to array
sa_RD  out  DIM*DATA_WIDTH  weight row to array, lane-packed
sa_FDi  out  DIM*DATA_WIDTH  skewed feature data to array, lane-packed

Behaviour:
- Reset (async assert, sync deassert by design): every output 0 except in_ready=1. State IDLE. Both buffer counts 0.
- Write interface:
  - A row is accepted on in_valid & in_ready. It is stored at index b_cnt or a_cnt, which then increments.
  - in_ready = (state==IDLE) & (in_sel ? a_cnt<ROWS : b_cnt<DIM).
  - A write to a full buffer stalls (ready=0). It never overwrites.
- Start:
  - Accepted only when state==IDLE, a_cnt==ROWS and b_cnt==DIM.
  - Otherwise start is ignored, with no latching.
  - If start and in_valid arrive in the same cycle, start is evaluated on the pre-write counts.
- State machine: IDLE -> LOAD_W -> FEED -> DONE -> IDLE. busy=1 in LOAD_W and FEED.
- LOAD_W:
  - Entered the cycle after start is accepted. Lasts exactly DIM cycles.
  - Cycle k (0..DIM-1): sa_load=1, sa_RD=B[k].
  - On exit, sa_load=0 and sa_RD=0.
- FEED:
  - Lasts ROWS+DIM-1 cycles, counter t=0..ROWS+DIM-2.
  - Lane j: sa_FDi[j] = A[t-j][j] if 0<=t-j<ROWS, else 0.
  - sa_load=0 throughout.
- DONE:
  - One cycle. done=1, sa_FDi=0, busy=0.
  - a_cnt cleared. b_cnt cleared unless the optional feature is enabled.
  - Returns to IDLE.
- All outputs are registered; no combinational path from inputs to sa_* outputs.
- Total job latency: start accepted at cycle 0, done at cycle DIM+ROWS+DIM.
- Reset mid-job: immediate return to reset values; buffered data is discarded (counts 0).
- start while busy: ignored.

Optional Feature:
SF_WEIGHT_REUSE_EN
- Defined:
  - b_cnt is retained after DONE.
  - A weights_valid flag is set when b_cnt reaches DIM.
  - While weights_valid=1, B writes are refused (ready=0 for in_sel=0) until a job completes with a_cnt and b_cnt both cleared via reset.
  - Start with weights_valid=1 and no new B since the last job skips LOAD_W: IDLE -> FEED directly, latency reduced by DIM.
  - The first job after reset always loads.
- Undefined: b_cnt is always cleared at DONE and every job runs LOAD_W.

Test Plan:
1. DIM=2, ROWS=2. Write B rows {1,2},{3,4} and A rows {5,6},{7,8}, then start. Required, cycles after start:
   - c1: load=1, RD={1,2}
   - c2: load=1, RD={3,4}
   - c3: FDi={5,0}
   - c4: FDi={7,6}
   - c5: FDi={0,8}
   - c6: done=1
   - c7: in_ready=1
   (Lane 0 listed first.)
2. Start with only one A row written -> no state change, busy=0, sa_load=0. A second A row then start -> job runs as in scenario 1.
3. Third B write with in_valid held -> in_ready=0 for in_sel=0 while in_ready=1 for in_sel=1. The stored B is unchanged (verified by the RD sequence).
4. Assert sa_rst_n=0 during FEED (t=1) -> all sa_* outputs 0 asynchronously, busy=0. After release, start without rewriting -> ignored.
5. start and in_valid (last A row) in the same cycle -> start ignored, row accepted. start next cycle -> accepted.
6. SF_WEIGHT_REUSE_EN defined: job 1 as in scenario 1. Write A {9,10},{11,12}, start -> c1 FDi={9,0}, c2 {11,10}, c3 {0,12}, c4 done=1; sa_load never asserted.
